// File: rtl/host_config_loader.sv
// rtl/host_config_loader.sv - assembles a wide configuration word from narrow host writes and commits it atomically
`ifndef H_C_W
`define H_C_W 80
`endif

module host_config_loader #(
  parameter int CFG_W     = `H_C_W,
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W,
  parameter int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [WORD_W-1:0] host_wr_data,
  input  logic              host_abort,
  output logic              cfg_valid,
  input  logic              cfg_ready,
  output logic [CFG_W-1:0]  Host_Config,
  output logic              cfg_update,
  output logic              busy,
  output logic [IDX_W-1:0]  word_idx,
  output logic [15:0]       cfg_count
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t           state;
  logic [CFG_W-1:0] shadow;
  logic [CFG_W-1:0] shadow_next;
  logic             accept;
  logic             last_word;

  assign host_wr_ready = !rst && (state != WAIT) && !host_abort;
  assign accept        = host_wr_valid && host_wr_ready;
  assign last_word     = (word_idx == LAST_IDX);

  // Bit-wise merge keeps bits of the last word above CFG_W out of the shadow entirely.
  always_comb begin
    shadow_next = shadow;
    for (int b = 0; b < CFG_W; b++) begin
      if (int'(word_idx) == b / WORD_W) shadow_next[b] = host_wr_data[b % WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_idx    <= '0;
      shadow      <= '0;
      Host_Config <= '0;
      cfg_valid   <= 1'b0;
      cfg_update  <= 1'b0;
      cfg_count   <= '0;
      busy        <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      if (host_abort) begin
        // Abort outranks a simultaneous commit; shadow is left for the next full rewrite.
        state     <= IDLE;
        word_idx  <= '0;
        cfg_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE, LOAD: begin
            if (accept) begin
              shadow <= shadow_next;
              busy   <= 1'b1;
              if (last_word) begin
                word_idx  <= '0;
                state     <= WAIT;
                cfg_valid <= 1'b1;
              end else begin
                word_idx <= word_idx + IDX_W'(1);
                state    <= LOAD;
              end
            end
          end
          WAIT: begin
            if (cfg_ready) begin
              Host_Config <= shadow;
              cfg_count   <= cfg_count + 16'd1;
              cfg_update  <= 1'b1;
              cfg_valid   <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
          default: begin
            state     <= IDLE;
            word_idx  <= '0;
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/host_config_loader.md
# host_config_loader

Host-side configuration writer that assembles the wide `H_C_W`-bit configuration word from a stream of narrow host bus writes. It holds the assembled word in a shadow register, then commits it atomically to the configuration decoder input through a valid/ready handshake. The decoder splits that word into SPM instruction, execution bus and LSU instruction fields. The committed word stays stable between commits, so the array never sees a partially written configuration.

## Interface
Parameters:
- `CFG_W`, default `` `H_C_W ``: width of the assembled configuration word.
- `WORD_W`, default 32: width of one host write word.
- `NUM_WORDS`, derived as ceil(CFG_W/WORD_W): host words per configuration. Minimum 1.
- `IDX_W`, derived as max(1, clog2(NUM_WORDS)): width of the word index.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `host_wr_valid` input, 1: host write word valid.
- `host_wr_ready` output, 1: loader can accept a word.
- `host_wr_data` input, WORD_W: host write word. The first word maps to the least-significant bits.
- `host_abort` input, 1: discards any in-progress assembly.
- `cfg_valid` output, 1: assembled configuration is pending commit.
- `cfg_ready` input, 1: consumer accepts the commit.
- `Host_Config` output, CFG_W: committed configuration word (registered).
- `cfg_update` output, 1: one-cycle pulse on the cycle after a commit.
- `busy` output, 1: high in LOAD or WAIT.
- `word_idx` output, IDX_W: index of the next word to be written.
- `cfg_count` output, 16: number of commits since reset, wraps at 0xFFFF→0.

## Operation
- FSM states: IDLE, LOAD, WAIT. Reset state is IDLE.
- IDLE → LOAD on the first accepted word when NUM_WORDS>1. IDLE → WAIT directly when NUM_WORDS==1.
- LOAD → WAIT when the word at index NUM_WORDS-1 is accepted.
- WAIT → IDLE when `cfg_valid && cfg_ready`.
- Word acceptance is `host_wr_valid && host_wr_ready`.
- On acceptance, `shadow[word_idx*WORD_W +: WORD_W] <= host_wr_data` and `word_idx` increments. `word_idx` returns to 0 after the last word.
- The last word is truncated: bits above CFG_W are discarded and never reach `Host_Config`.
- `host_wr_ready = !rst && (state != WAIT) && !host_abort`. This is combinational from registered state.
- `cfg_valid` is high exactly while in WAIT.
- On commit (`cfg_valid && cfg_ready`):
  - `Host_Config <= shadow`.
  - `cfg_count` increments.
  - `cfg_update` is 1 on the following cycle only.
- `host_abort` in any state:
  - Next state is IDLE and `word_idx` becomes 0.
  - No commit occurs, even if `cfg_ready` is high in the same cycle (abort has priority).
  - `Host_Config` and `cfg_count` are unchanged.
  - Shadow contents are left as-is but are never committed unless fully rewritten.
- Shadow words not rewritten in a later assembly retain their previous values. Every assembly writes all NUM_WORDS words, so no stale data is committed.
- `busy = (state != IDLE)`.

## Timing
- Reset (`rst` high at a clock edge) forces: state IDLE, `word_idx`=0, shadow=0, `Host_Config`=0, `cfg_valid`=0, `cfg_update`=0, `cfg_count`=0, `busy`=0.
- While `rst` is high, `host_wr_ready`=0.
- Reset mid-assembly or in WAIT discards everything. No commit occurs.
- Accepting one word per cycle takes NUM_WORDS cycles. `cfg_valid` rises on the cycle after the last word is accepted.
- With `cfg_ready` tied high:
  - Commit happens in the first WAIT cycle.
  - `Host_Config` shows the new value and `cfg_update`=1 one cycle later.
  - `host_wr_ready` returns to 1 on that same cycle.
  - Throughput is NUM_WORDS+1 cycles per configuration.
- `host_wr_valid` may toggle freely. Gaps stall assembly with no timeout.
- `cfg_ready` may be asserted at any time. It has no effect outside WAIT.
- `Host_Config` changes only on the commit edge or on reset.

## Test plan
All scenarios use CFG_W=80, WORD_W=32, NUM_WORDS=3.
- Basic commit, `cfg_ready`=1: write 0x11111111, 0x22222222, 0xFFFF3333 back-to-back.
  - `cfg_valid`=1 on cycle 4.
  - `Host_Config`=80'h3333_22222222_11111111 and `cfg_update`=1 on cycle 5.
  - `cfg_count`=1.
- Backpressure: same writes with `cfg_ready`=0 for 5 cycles.
  - `cfg_valid` holds high and `host_wr_ready`=0 throughout.
  - A 4th word offered with `host_wr_valid`=1 is not accepted.
  - `Host_Config` stays 0 until `cfg_ready` rises, then updates with a single `cfg_update` pulse.
- Abort: write 2 words, then assert `host_abort` together with `host_wr_valid`.
  - The word is not accepted and `word_idx`=0.
  - Writing 0xA, 0xB, 0xC then commits 80'h000C_0000000B_0000000A.
- Abort in WAIT with `cfg_ready`=1 in the same cycle: no commit, `cfg_count` unchanged, state IDLE.
- Reset mid-operation: `rst` after 1 word.
  - All outputs return to reset values.
  - A fresh 3-word write commits correctly with `cfg_count`=1.
- Wrap: preload by issuing 65536 commits. `cfg_count` reads 0 after the last one, and `Host_Config` equals the final assembled word.
